alu_16: RTL and testbench

- 16-bit signed two-operand ALU with a 3-bit opcode, carry-in, and zero/negative status flags.
- Result and flags are registered: one clock of latency, asynchronous active-high reset.
- Used as the datapath arithmetic block.
- Two implementations exist (behavioural ALU16, structural ALU16_y); both shall implement this spec and be bit-identical on every cycle.

---
 rtl/alu_16_pkg.sv | 17 +
 rtl/alu_16_adder.sv | 26 ++
 rtl/alu_16.sv | 85 ++++++++
 tb/tb_alu_16.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_16_pkg.sv
// rtl/alu_16_pkg.sv - shared width constant and opcode encoding for alu_16
package alu_16_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_ASR = 3'b110,
    OP_SLT = 3'b111
  } opcode_e;

endpackage

// File: rtl/alu_16_adder.sv
// rtl/alu_16_adder.sv - WIDTH-bit adder, behavioural or full-adder ripple chain
module alu_16_adder #(
  parameter int WIDTH      = 16,
  parameter bit STRUCTURAL = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  if (STRUCTURAL) begin : g_ripple
    // c[i] is the carry into bit i; the carry out of the MSB is never needed
    logic [WIDTH-1:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i] = a[i] ^ b[i] ^ c[i];
      if (i < WIDTH - 1) begin : g_carry
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
    end
  end else begin : g_behav
    assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};
  end

endmodule

// File: rtl/alu_16.sv
// rtl/alu_16.sv - 16-bit signed ALU with registered result and zero/negative flags
module alu_16 #(
  parameter int WIDTH      = alu_16_pkg::WIDTH,
  parameter bit STRUCTURAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] MM,
  input  logic [WIDTH-1:0] NN,
  input  logic             cc,
  input  logic [2:0]       opc,
  output logic [WIDTH-1:0] outF,
  output logic             zer,
  output logic             neg
);

  import alu_16_pkg::*;

  opcode_e          op;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             ovf;
  logic             lt;
  logic [WIDTH-1:0] outF_d, outF_q;
  logic             zer_d, zer_q;
  logic             neg_d, neg_q;

  assign op = opcode_e'(opc);

  // SUB and SLT both need MM + ~NN; SLT forces cin=1 so cc cannot skew the compare
  always_comb begin
    add_b   = ~NN;
    add_cin = 1'b1;
    if (op == OP_ADD) add_b = NN;
    if (op == OP_ADD || op == OP_SUB) add_cin = cc;
  end

  alu_16_adder #(
    .WIDTH      (WIDTH),
    .STRUCTURAL (STRUCTURAL)
  ) u_adder (
    .a   (MM),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum)
  );

  assign ovf = (MM[WIDTH-1] ^ NN[WIDTH-1]) & (add_sum[WIDTH-1] ^ MM[WIDTH-1]);
  assign lt  = add_sum[WIDTH-1] ^ ovf;

  always_comb begin
    outF_d = '0;
    case (op)
      OP_ADD,
      OP_SUB:  outF_d = add_sum;
      OP_AND:  outF_d = MM & NN;
      OP_OR:   outF_d = MM | NN;
      OP_XOR:  outF_d = MM ^ NN;
      OP_NOT:  outF_d = ~MM;
      OP_ASR:  outF_d = {MM[WIDTH-1], MM[WIDTH-1:1]};
      OP_SLT:  outF_d = {{(WIDTH-1){1'b0}}, lt};
      default: outF_d = '0;
    endcase
    zer_d = (outF_d == '0);
    neg_d = outF_d[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outF_q <= '0;
      zer_q  <= 1'b1;
      neg_q  <= 1'b0;
    end else begin
      outF_q <= outF_d;
      zer_q  <= zer_d;
      neg_q  <= neg_d;
    end
  end

  assign outF = outF_q;
  assign zer  = zer_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_alu_16.sv
// tb/tb_alu_16.sv - self-checking bench for alu_16, behavioural and ripple-adder builds
module tb_alu_16;

  logic        clk;
  logic        rst;
  logic [15:0] MM, NN;
  logic        cc;
  logic [2:0]  opc;
  logic [15:0] outF_b, outF_s;
  logic        zer_b, zer_s, neg_b, neg_s;

  int checks;
  int errors;

  alu_16 #(.WIDTH(16), .STRUCTURAL(1'b0)) dut_b (
    .clk (clk), .rst (rst), .MM (MM), .NN (NN), .cc (cc), .opc (opc),
    .outF (outF_b), .zer (zer_b), .neg (neg_b)
  );

  alu_16 #(.WIDTH(16), .STRUCTURAL(1'b1)) dut_s (
    .clk (clk), .rst (rst), .MM (MM), .NN (NN), .cc (cc), .opc (opc),
    .outF (outF_s), .zer (zer_s), .neg (neg_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic [2:0] op);
    int sa;
    int sb;
    int r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: r = int'(a) + int'(b) + int'(c);
      3'd1: r = int'(a) - int'(b) - 1 + int'(c);
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(~a);
      3'd6: r = (sa < 0) ? -((-sa + 1) / 2) : sa / 2;
      default: r = (sa < sb) ? 1 : 0;
    endcase
    return r[15:0];
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [15:0] r);
    check16({tag, "_outF_b"}, outF_b, r);
    check1 ({tag, "_zer_b"},  zer_b,  r == 16'h0000);
    check1 ({tag, "_neg_b"},  neg_b,  r[15]);
    check16({tag, "_outF_s"}, outF_s, r);
    check1 ({tag, "_zer_s"},  zer_s,  r == 16'h0000);
    check1 ({tag, "_neg_s"},  neg_s,  r[15]);
  endtask

  // Drive one operation, clock it, and check against both the model and a literal
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [2:0] op, input logic [15:0] lit);
    logic [15:0] r;
    MM = a; NN = b; cc = c; opc = op;
    r = model(a, b, c, op);
    @(posedge clk);
    #1;
    check16({tag, "_model"}, r, lit);
    check_both(tag, lit);
  endtask

  initial begin
    logic [15:0] a, b, r;
    logic [2:0]  op;
    logic        c;
    checks = 0;
    errors = 0;
    rst = 1'b1; MM = '0; NN = '0; cc = 1'b1; opc = 3'd0;
    #12;
    check_both("reset_init", 16'h0000);
    rst = 1'b0;

    // Load 0x1234, then assert reset mid-cycle and check without a clock edge
    step("load", 16'h1234, 16'h0000, 1'b0, 3'd0, 16'h1234);
    #2;
    rst = 1'b1;
    #1;
    check_both("reset_async", 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    step("add_wrap",  16'h7FFF, 16'h0000, 1'b1, 3'd0, 16'h8000);
    step("add_cc0",   16'hFFFF, 16'h0001, 1'b0, 3'd0, 16'h0000);
    step("sub_zero",  16'h0005, 16'h0005, 1'b1, 3'd1, 16'h0000);
    step("sub_neg",   16'h0003, 16'h0005, 1'b1, 3'd1, 16'hFFFE);
    step("sub_cc0",   16'h0005, 16'h0005, 1'b0, 3'd1, 16'hFFFF);
    step("and",       16'hF0F0, 16'h0FF0, 1'b1, 3'd2, 16'h00F0);
    step("or",        16'hF0F0, 16'h0FF0, 1'b1, 3'd3, 16'hFFF0);
    step("xor",       16'hF0F0, 16'h0FF0, 1'b1, 3'd4, 16'hFF00);
    step("not",       16'hF0F0, 16'h0FF0, 1'b0, 3'd5, 16'h0F0F);
    step("asr_neg",   16'h8004, 16'h0000, 1'b1, 3'd6, 16'hC002);
    step("asr_pos",   16'h7FFF, 16'h0000, 1'b0, 3'd6, 16'h3FFF);
    step("slt_true",  16'hFFFE, 16'h0001, 1'b1, 3'd7, 16'h0001);
    step("slt_ovf",   16'h7FFF, 16'h8000, 1'b1, 3'd7, 16'h0000);
    step("slt_ovf2",  16'h8000, 16'h7FFF, 1'b0, 3'd7, 16'h0001);
    step("slt_eq",    16'h1234, 16'h1234, 1'b0, 3'd7, 16'h0000);

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); op = 3'($urandom_range(0, 7));
      MM = a; NN = b; cc = 1'b1; opc = op;
      r = model(a, b, 1'b1, op);
      @(posedge clk);
      #1;
      check_both("rand", r);
    end

    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom); b = 16'($urandom); op = 3'($urandom_range(0, 7));
      c = 1'($urandom);
      MM = a; NN = b; cc = c; opc = op;
      r = model(a, b, c, op);
      @(posedge clk);
      #1;
      check_both("rand_cc", r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
